// File: rtl/ballot_box_arbiter.sv
// Election front-end: sequences REGISTER -> VOTING -> RESULT, rejects requests illegal for the
// current phase and round-robin issues legal ones, one per cycle, to the vote datapath.
module ballot_box_arbiter #(
    parameter int REG_CYCLES  = 100,
    parameter int VOTE_CYCLES = 100
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  req,
    input  logic [7:0]  reqMode,
    input  logic [15:0] reqId,
    input  logic [7:0]  reqCand,
    output logic [3:0]  gnt,
    output logic [3:0]  rej,
    output logic        outValid,
    output logic [1:0]  outMode,
    output logic [5:0]  outUserID,
    output logic [1:0]  outCandidate,
    output logic [1:0]  phase,
    output logic        tallyStart
);

    localparam int TOTAL_CYCLES = REG_CYCLES + VOTE_CYCLES;
    localparam int CNT_W        = $clog2(TOTAL_CYCLES + 1);
    localparam logic [CNT_W-1:0] REG_END  = CNT_W'(REG_CYCLES);
    localparam logic [CNT_W-1:0] VOTE_END = CNT_W'(TOTAL_CYCLES);
    localparam logic [1:0] MODE_REGISTER = 2'b00;
    localparam logic [1:0] MODE_VOTE     = 2'b01;

    typedef enum logic [1:0] {
        PH_REGISTER = 2'b00,
        PH_VOTING   = 2'b01,
        PH_RESULT   = 2'b10
    } phase_t;

    logic [CNT_W-1:0] cnt_reg, cnt_next;
    phase_t           phase_reg, phase_cur;
    logic [1:0]       ptr_reg, ptr_next;
    logic [3:0]       mask_reg;
    logic [3:0]       gnt_reg, gnt_next;
    logic [3:0]       rej_reg, rej_next;
    logic             out_valid_reg, out_valid_next;
    logic [1:0]       out_mode_reg, out_mode_next;
    logic [5:0]       out_user_reg, out_user_next;
    logic [1:0]       out_cand_reg, out_cand_next;
    logic             tally_reg, tally_next;

    logic [1:0] mode_arr [4];
    logic [3:0] id_arr   [4];
    logic [1:0] cand_arr [4];
    logic [3:0] legal;
    logic [3:0] eligible;
    logic       found;
    logic [1:0] grant_idx;
    logic [1:0] scan_idx;

    // The phase for this edge comes from the count before it advances.
    always_comb begin
        phase_cur = PH_RESULT;
        if (cnt_reg < REG_END) begin
            phase_cur = PH_REGISTER;
        end else if (cnt_reg < VOTE_END) begin
            phase_cur = PH_VOTING;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_term
            assign mode_arr[gi] = reqMode[2*gi +: 2];
            assign id_arr[gi]   = reqId[4*gi +: 4];
            assign cand_arr[gi] = reqCand[2*gi +: 2];
            assign legal[gi]    = req[gi] &&
                ((phase_cur == PH_REGISTER && mode_arr[gi] == MODE_REGISTER) ||
                 (phase_cur == PH_VOTING   && mode_arr[gi] == MODE_VOTE));
        end
    endgenerate

    // Rejection ignores the grant mask: a stale-but-illegal request is still bounced.
    assign rej_next = req & ~legal;
    assign eligible = legal & ~mask_reg;

    always_comb begin : arbitrate
        found     = 1'b0;
        grant_idx = ptr_reg;
        scan_idx  = ptr_reg;
        for (int off = 1; off <= 4; off++) begin
            scan_idx = ptr_reg + 2'(off);
            if (!found && eligible[scan_idx]) begin
                found     = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin : next_state
        gnt_next       = 4'b0000;
        ptr_next       = ptr_reg;
        out_valid_next = 1'b0;
        out_mode_next  = 2'b00;
        out_user_next  = 6'b000000;
        out_cand_next  = 2'b00;
        cnt_next       = (cnt_reg == VOTE_END) ? cnt_reg : cnt_reg + 1'b1;
        tally_next     = (phase_cur == PH_RESULT) && (phase_reg != PH_RESULT);
        if (found) begin
            gnt_next[grant_idx] = 1'b1;
            ptr_next            = grant_idx;
            out_valid_next      = 1'b1;
            out_mode_next       = mode_arr[grant_idx];
            out_user_next       = {grant_idx, id_arr[grant_idx]};
            out_cand_next       = (mode_arr[grant_idx] == MODE_VOTE) ? cand_arr[grant_idx] : 2'b00;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_reg       <= '0;
            phase_reg     <= PH_REGISTER;
            ptr_reg       <= 2'd3;
            mask_reg      <= 4'b0000;
            gnt_reg       <= 4'b0000;
            rej_reg       <= 4'b0000;
            out_valid_reg <= 1'b0;
            out_mode_reg  <= 2'b00;
            out_user_reg  <= 6'b000000;
            out_cand_reg  <= 2'b00;
            tally_reg     <= 1'b0;
        end else begin
            cnt_reg       <= cnt_next;
            phase_reg     <= phase_cur;
            ptr_reg       <= ptr_next;
            mask_reg      <= gnt_next;
            gnt_reg       <= gnt_next;
            rej_reg       <= rej_next;
            out_valid_reg <= out_valid_next;
            out_mode_reg  <= out_mode_next;
            out_user_reg  <= out_user_next;
            out_cand_reg  <= out_cand_next;
            tally_reg     <= tally_next;
        end
    end

    assign gnt          = gnt_reg;
    assign rej          = rej_reg;
    assign outValid     = out_valid_reg;
    assign outMode      = out_mode_reg;
    assign outUserID    = out_user_reg;
    assign outCandidate = out_cand_reg;
    assign phase        = phase_reg;
    assign tallyStart   = tally_reg;

endmodule

// File: tb/tb_ballot_box_arbiter.sv
// Directed + randomized bench for ballot_box_arbiter against an edge-counting reference model.
module tb_ballot_box_arbiter;

    localparam int REG_CYCLES  = 100;
    localparam int VOTE_CYCLES = 100;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [7:0]  reqMode = 8'h00;
    logic [15:0] reqId = 16'h0000;
    logic [7:0]  reqCand = 8'h00;
    logic [3:0]  gnt, rej;
    logic        outValid;
    logic [1:0]  outMode;
    logic [5:0]  outUserID;
    logic [1:0]  outCandidate;
    logic [1:0]  phase;
    logic        tallyStart;

    ballot_box_arbiter #(.REG_CYCLES(REG_CYCLES), .VOTE_CYCLES(VOTE_CYCLES)) dut (
        .CLK(CLK), .RST(RST), .req(req), .reqMode(reqMode), .reqId(reqId), .reqCand(reqCand),
        .gnt(gnt), .rej(rej), .outValid(outValid), .outMode(outMode), .outUserID(outUserID),
        .outCandidate(outCandidate), .phase(phase), .tallyStart(tallyStart)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: edges since reset, last granted terminal, last-cycle grant.
    int m_edges = 0;
    int m_ptr   = 3;
    int m_last  = -1;
    logic [3:0] last_e_gnt = 4'b0000;
    logic [3:0] last_e_rej = 4'b0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Predict the outcome of the coming edge from the current inputs, take the edge, compare.
    task automatic tick();
        logic [3:0] e_gnt, e_rej;
        logic       e_valid, e_tally;
        logic [1:0] e_mode, e_cand, e_phase, md;
        logic [5:0] e_uid;
        int ph, g, t, edge_no;
        e_gnt = 4'b0000; e_rej = 4'b0000; e_valid = 1'b0; e_tally = 1'b0;
        e_mode = 2'b00; e_cand = 2'b00; e_phase = 2'b00; e_uid = 6'b000000;
        g = -1;
        edge_no = m_edges + 1;
        if (RST) begin
            m_edges = 0; m_ptr = 3; m_last = -1; edge_no = 0;
        end else begin
            ph = (m_edges < REG_CYCLES) ? 0 : (m_edges < REG_CYCLES + VOTE_CYCLES) ? 1 : 2;
            e_phase = 2'(ph);
            e_tally = (edge_no == REG_CYCLES + VOTE_CYCLES + 1);
            for (int i = 0; i < 4; i++) begin
                md = reqMode[2*i +: 2];
                if (req[i] && !((ph == 0 && md == 2'b00) || (ph == 1 && md == 2'b01)))
                    e_rej[i] = 1'b1;
            end
            for (int k = 1; k <= 4; k++) begin
                t = (m_ptr + k) % 4;
                if (g < 0 && req[t] && !e_rej[t] && t != m_last) g = t;
            end
            if (g >= 0) begin
                e_gnt[g] = 1'b1;
                e_valid  = 1'b1;
                e_mode   = reqMode[2*g +: 2];
                e_uid    = {2'(g), reqId[4*g +: 4]};
                e_cand   = (e_mode == 2'b01) ? reqCand[2*g +: 2] : 2'b00;
                m_ptr    = g;
            end
            m_last = g;
            m_edges++;
        end
        @(posedge CLK);
        #1;
        check($sformatf("gnt@e%0d", edge_no), 32'(gnt), 32'(e_gnt));
        check($sformatf("rej@e%0d", edge_no), 32'(rej), 32'(e_rej));
        check($sformatf("out@e%0d", edge_no), 32'({outValid, outMode, outUserID, outCandidate}),
              32'({e_valid, e_mode, e_uid, e_cand}));
        check($sformatf("phase@e%0d", edge_no), 32'(phase), 32'(e_phase));
        check($sformatf("tally@e%0d", edge_no), 32'(tallyStart), 32'(e_tally));
        $display("edge %0d rst=%0b req=%b mode=%h -> gnt=%b rej=%b valid=%0b uid=%h cand=%0d phase=%0d tally=%0b",
                 edge_no, RST, req, reqMode, gnt, rej, outValid, outUserID, outCandidate, phase, tallyStart);
        last_e_gnt = e_gnt;
        last_e_rej = e_rej;
    endtask

    // Terminals drop a request once it has been answered.
    task automatic react();
        req = req & ~(last_e_gnt | last_e_rej);
    endtask

    task automatic rand_drive();
        for (int i = 0; i < 4; i++) begin
            if (!req[i] && $urandom_range(0, 99) < 45) begin
                int r;
                r = $urandom_range(0, 9);
                req[i] = 1'b1;
                reqMode[2*i +: 2] = (r < 5) ? 2'b00 : (r < 8) ? 2'b01 : 2'($urandom_range(2, 3));
                reqId[4*i +: 4]   = 4'($urandom_range(0, 15));
                reqCand[2*i +: 2] = 2'($urandom_range(0, 3));
            end
        end
    endtask

    task automatic run_random(input int until_edges);
        while (m_edges < until_edges) begin
            rand_drive();
            tick();
            react();
        end
    endtask

    task automatic run_idle(input int until_edges);
        req = 4'b0000;
        while (m_edges < until_edges) tick();
    endtask

    initial begin
        int order[$];

        // Reset state
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;

        // Single register request on edge 1
        req = 4'b0001; reqMode = 8'h00; reqId = 16'h0005; reqCand = 8'h00;
        tick();
        check("t1_gnt", 32'(gnt), 32'h1);
        check("t1_uid", 32'(outUserID), 32'b000101);
        check("t1_valid", 32'(outValid), 32'h1);
        react();

        // Four continuous requesters from a fresh reset: round-robin order 0,1,2,3
        RST = 1'b1;
        tick();
        RST = 1'b0;
        req = 4'b1111; reqMode = 8'h00; reqId = 16'h4321; reqCand = 8'hE4;
        for (int c = 0; c < 8 && order.size() < 4; c++) begin
            tick();
            for (int i = 0; i < 4; i++) if (last_e_gnt[i]) order.push_back(i);
            react();
        end
        check("t2_count", 32'(order.size()), 32'd4);
        for (int k = 0; k < order.size(); k++) check($sformatf("t2_order%0d", k), 32'(order[k]), 32'(k));

        // Random REGISTER traffic, then the REGISTER/VOTING boundary
        run_random(REG_CYCLES - 3);
        run_idle(REG_CYCLES - 1);
        req = 4'b0100; reqMode = 8'h00; reqId = 16'h0900;
        tick();
        check("t3_last_reg_gnt", 32'(gnt), 32'b0100);
        check("t3_last_reg_uid", 32'(outUserID), 32'b101001);
        tick();
        check("t3_first_vote_rej", 32'(rej), 32'b0100);
        check("t3_first_vote_phase", 32'(phase), 32'b01);
        check("t3_first_vote_valid", 32'(outValid), 32'h0);
        req = 4'b0000;

        // Random VOTING traffic, then a mixed legal/illegal pair at edge 150
        run_random(REG_CYCLES + 47);
        run_idle(REG_CYCLES + 49);
        req = 4'b0011; reqMode = 8'b0000_0001; reqId = 16'h0072; reqCand = 8'b0000_0111;
        tick();
        check("t4_gnt", 32'(gnt), 32'b0001);
        check("t4_cand", 32'(outCandidate), 32'b11);
        check("t4_rej", 32'(rej), 32'b0010);
        check("t4_uid", 32'(outUserID), 32'b000010);
        react();

        // Into RESULT: tally pulse, every request rejected
        run_random(REG_CYCLES + VOTE_CYCLES);
        req = 4'b1111; reqMode = 8'($urandom_range(0, 255)); reqCand = 8'($urandom_range(0, 255));
        tick();
        check("t5_phase", 32'(phase), 32'b10);
        check("t5_tally", 32'(tallyStart), 32'h1);
        check("t5_rej", 32'(rej), 32'hF);
        check("t5_gnt", 32'(gnt), 32'h0);
        react();
        rand_drive();
        tick();
        check("t5_tally_once", 32'(tallyStart), 32'h0);
        react();
        run_random(REG_CYCLES + VOTE_CYCLES + 10);

        // Reset mid-VOTING aborts the election
        RST = 1'b1;
        tick();
        RST = 1'b0;
        run_random(REG_CYCLES + 49);
        RST = 1'b1;
        req = 4'b1111; reqMode = 8'b0101_0101;
        tick();
        check("t6_rst_gnt", 32'(gnt), 32'h0);
        check("t6_rst_valid", 32'(outValid), 32'h0);
        check("t6_rst_phase", 32'(phase), 32'b00);
        RST = 1'b0;
        req = 4'b0001; reqMode = 8'b0000_0001;
        tick();
        check("t6_vote_rej", 32'(rej), 32'b0001);
        check("t6_phase", 32'(phase), 32'b00);
        react();
        run_random(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
